// File: rtl/hoaaned_pipe.sv
// hoaaned_pipe: two-stage approximate/exact adder pipeline with valid/ready handshakes.
// Define HOAANED_PIPE_ERR_MON_EN to build the approximation error monitor.
module hoaaned_pipe #(
   parameter int N    = 16,
   parameter int P    = 8,
   parameter int ERRW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_x,
   input  logic [N-1:0]    in_y,
   input  logic            in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N:0]      out_sum,
   input  logic            err_clr,
   output logic [ERRW-1:0] err_cnt,
   output logic [N:0]      err_max
);
   logic           s1_v, s1_m, s2_v, s2_adv, c;
   logic [N-1:0]   s1_x, s1_y;
   logic [N:0]     s2_sum, ex, apx, res;
   logic [P-1:0]   lo;
   logic [N-P:0]   hi;
   assign s2_adv    = !s2_v || out_ready;
   assign in_ready  = !s1_v || s2_adv;
   assign out_valid = s2_v;
   assign out_sum   = s2_sum;
   always_comb begin
      c       = s1_x[P-1] & s1_y[P-1];
      lo      = '1;
      lo[P-1] = (c ? 1'b0 : s1_x[P-1] | s1_y[P-1]) | (s1_x[P-2] & s1_y[P-2]);
      lo[P-2] = s1_x[P-2] | s1_y[P-2];
      hi      = {1'b0, s1_x[N-1:P]} + {1'b0, s1_y[N-1:P]} + (N-P+1)'(c);
      apx     = {hi, lo};
      ex      = {1'b0, s1_x} + {1'b0, s1_y};
      res     = s1_m ? ex : apx;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         s2_sum <= '0;
      end else begin
         if (in_ready) begin
            s1_v <= in_valid;
            s1_x <= in_x;
            s1_y <= in_y;
            s1_m <= in_mode;
         end
         if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) s2_sum <= res;
         end
      end
   end
`ifdef HOAANED_PIPE_ERR_MON_EN
   logic       s2_apx;
   logic [N:0] s2_d, d;
   assign d = apx > ex ? apx - ex : ex - apx;
   // error distance travels with its result so the monitor updates on the output transfer
   always_ff @(posedge clk) begin
      if (s2_adv && s1_v) begin
         s2_apx <= !s1_m;
         s2_d   <= d;
      end
      if (!rst_n) begin
         err_cnt <= '0;
         err_max <= '0;
      end else if (err_clr) begin
         err_cnt <= '0;
         err_max <= '0;
      end else if (s2_v && out_ready && s2_apx) begin
         if (s2_d != '0 && !(&err_cnt)) err_cnt <= err_cnt + ERRW'(1);
         if (s2_d > err_max) err_max <= s2_d;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = err_clr;
   assign err_cnt    = '0;
   assign err_max    = '0;
`endif
endmodule

// File: tb/tb_hoaaned_pipe.sv
// tb_hoaaned_pipe: randomized and directed checks of hoaaned_pipe against a queue-based reference model.
module tb_hoaaned_pipe;
   localparam int N = 16, P = 8, ERRW = 32;
`ifdef HOAANED_PIPE_ERR_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif
   logic            clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
   logic [N-1:0]    in_x = '0, in_y = '0;
   logic            in_ready, out_valid;
   logic [N:0]      out_sum, err_max;
   logic [ERRW-1:0] err_cnt;

   hoaaned_pipe #(.N(N), .P(P), .ERRW(ERRW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .err_clr(err_clr),
      .err_cnt(err_cnt), .err_max(err_max)
   );

   always #5 clk = ~clk;

   typedef struct {logic [N-1:0] x; logic [N-1:0] y; logic m; int t;} item_t;
   item_t           q[$];
   int              tests = 0, fails = 0, now = 0;
   logic [ERRW-1:0] mcnt = '0;
   logic [N:0]      mmax = '0;

   // Reference: exact is plain addition; approximate follows the bit rules with integer arithmetic.
   function automatic logic [N:0] ref_sum(input logic [N-1:0] x, input logic [N-1:0] y, input logic m);
      int unsigned xi, yi, c, b1, b0, hi, lo;
      xi = 32'(x);
      yi = 32'(y);
      if (m) return (N+1)'(xi + yi);
      c  = 32'(x[P-1] & y[P-1]);
      b1 = (c != 0) ? 32'(x[P-2] & y[P-2]) : 32'(x[P-1] | y[P-1] | (x[P-2] & y[P-2]));
      b0 = 32'(x[P-2] | y[P-2]);
      hi = (xi >> P) + (yi >> P) + c;
      lo = (b1 << (P-1)) | (b0 << (P-2)) | ((32'd1 << (P-2)) - 32'd1);
      return (N+1)'((hi << P) | lo);
   endfunction

   task automatic step(input logic v, input logic [N-1:0] x, input logic [N-1:0] y, input logic m,
                       input logic ordy, input logic clr, output logic acc);
      int unsigned a, e, d;
      logic exp_ov;
      logic [ERRW-1:0] ecnt;
      logic [N:0] emax;
      @(negedge clk);
      in_valid = v; in_x = x; in_y = y; in_mode = m; out_ready = ordy; err_clr = clr;
      #1;
      tests++;
      if (in_ready !== (ordy || q.size() < 2)) begin
         fails++;
         $display("FAIL in_ready step %0d: got %b expected %b", now, in_ready, ordy || q.size() < 2);
      end
      exp_ov = q.size() > 0 && (now - q[0].t) >= 2;
      tests++;
      if (out_valid !== exp_ov) begin
         fails++;
         $display("FAIL out_valid step %0d: got %b expected %b", now, out_valid, exp_ov);
      end
      if (out_valid === 1'b1 && q.size() > 0) begin
         tests++;
         if (out_sum !== ref_sum(q[0].x, q[0].y, q[0].m)) begin
            fails++;
            $display("FAIL out_sum step %0d: got %h expected %h", now, out_sum, ref_sum(q[0].x, q[0].y, q[0].m));
         end
      end
      ecnt = MON ? mcnt : '0;
      emax = MON ? mmax : '0;
      tests++;
      if (err_cnt !== ecnt || err_max !== emax) begin
         fails++;
         $display("FAIL err_regs step %0d: got cnt=%0d max=%h expected cnt=%0d max=%h", now, err_cnt, err_max, ecnt, emax);
      end
      if (out_valid === 1'b1 && ordy && q.size() > 0) begin
         if (!q[0].m) begin
            a = 32'(ref_sum(q[0].x, q[0].y, 1'b0));
            e = 32'(ref_sum(q[0].x, q[0].y, 1'b1));
            d = a > e ? a - e : e - a;
            if (d != 0 && mcnt != '1) mcnt = mcnt + ERRW'(1);
            if (d > 32'(mmax)) mmax = (N+1)'(d);
         end
         void'(q.pop_front());
      end
      if (clr) begin
         mcnt = '0;
         mmax = '0;
      end
      acc = v && (in_ready === 1'b1);
      if (acc) q.push_back('{x, y, m, now});
      now++;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
   endtask

   task automatic test_reset(input int n);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom); out_ready = 1'($urandom); in_x = N'($urandom); in_y = N'($urandom);
         #1;
         tests++;
         if (out_valid !== 1'b0 || out_sum !== '0 || err_cnt !== '0 || err_max !== '0) begin
            fails++;
            $display("FAIL reset_state: got ov=%b sum=%h cnt=%0d max=%h expected 0 0 0 0", out_valid, out_sum, err_cnt, err_max);
         end
      end
      q.delete();
      mcnt = '0;
      mmax = '0;
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic vec(input logic [N-1:0] x, input logic [N-1:0] y, input logic m,
                      input logic [N:0] exp_sum, input int exp_cnt, input logic [N:0] exp_max);
      logic acc;
      logic [ERRW-1:0] ec;
      logic [N:0] em;
      step(1'b1, x, y, m, 1'b1, 1'b0, acc);
      idle(2);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== exp_sum) begin
         fails++;
         $display("FAIL vector %h+%h m=%b: got ov=%b sum=%h expected ov=1 sum=%h", x, y, m, out_valid, out_sum, exp_sum);
      end
      idle(1);
      ec = MON ? ERRW'(exp_cnt) : '0;
      em = MON ? exp_max : '0;
      tests++;
      if (err_cnt !== ec || err_max !== em) begin
         fails++;
         $display("FAIL vector_mon %h+%h: got cnt=%0d max=%h expected cnt=%0d max=%h", x, y, err_cnt, err_max, ec, em);
      end
   endtask

   task automatic test_vectors;
      vec(16'h00FF, 16'h0001, 1'b0, 17'h000FF, 1, 17'h001);
      vec(16'h0080, 16'h0080, 1'b0, 17'h0013F, 2, 17'h03F);
      vec(16'hFFFF, 16'h0001, 1'b1, 17'h10000, 2, 17'h03F);
   endtask

   task automatic test_clr_coincident;
      logic acc;
      step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, acc);
      idle(1);
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
      idle(1);
      tests++;
      if (err_cnt !== '0 || err_max !== '0) begin
         fails++;
         $display("FAIL clr_coincident: got cnt=%0d max=%h expected 0 0", err_cnt, err_max);
      end
   endtask

   task automatic test_stall;
      int sent = 0;
      bit blocked = 1'b0;
      logic acc;
      for (int i = 0; i < 40 && (sent < 8 || q.size() > 0); i++) begin
         step(sent < 8, N'($urandom), N'($urandom), 1'($urandom), !(i >= 3 && i <= 6), 1'b0, acc);
         if (sent < 8 && !acc) blocked = 1'b1;
         if (acc) sent++;
      end
      tests++;
      if (sent != 8 || q.size() != 0 || !blocked) begin
         fails++;
         $display("FAIL stall: got sent=%0d left=%0d blocked=%b expected 8 0 1", sent, q.size(), blocked);
      end
   endtask

   task automatic test_reset_inflight;
      logic acc;
      step(1'b1, N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0, acc);
      test_reset(1);
      idle(4);
   endtask

   task automatic test_random(input int n);
      logic acc;
      for (int i = 0; i < n; i++)
         step($urandom_range(3) != 0, N'($urandom), N'($urandom), 1'($urandom),
              $urandom_range(3) != 0, $urandom_range(49) == 0, acc);
      for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
   endtask

   initial begin
      test_reset(3);
      test_vectors();
      test_clr_coincident();
      test_stall();
      test_random(400);
      test_reset_inflight();
      test_random(200);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hoaaned_pipe.md
HOAANED_PIPE -- requirements
Module: hoaaned_pipe

Interface
REQ-001 Parameter N, default 16: operand width in bits.
REQ-002 Parameter P, default 8: width of the approximate low part; legal range 2 <= P <= N-1.
REQ-003 Parameter ERRW, default 32: width of the error-monitor registers.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  an operand pair is presented.
REQ-007 in_ready  output  1  the block can accept an operand pair.
REQ-008 in_x, in_y  input  N each  operands, unsigned.
REQ-009 in_mode  input  1  0 = approximate add, 1 = exact add; sampled together with the operands.
REQ-010 out_valid  output  1  out_sum holds a result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_sum  output  N+1  result, with the carry-out in the MSB.
REQ-013 err_clr  input  1  clears the error-monitor registers.
REQ-014 err_cnt  output  ERRW  number of approximate results that differ from the exact sum.
REQ-015 err_max  output  N+1  largest absolute error distance seen so far.

Function
REQ-016 A transfer SHALL occur on a clock edge where in_valid && in_ready; an output transfer SHALL occur on a clock edge where out_valid && out_ready.
REQ-017 The datapath SHALL have two register stages:
- S1 registers operands and mode.
- S2 registers the result.
- Latency SHALL be 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-018 Each stage SHALL load when it is empty or its contents move on in the same cycle.
- in_ready = !S1_valid || S1 advances.
- Full throughput of one result per cycle SHALL be sustained when out_ready = 1.
REQ-019 With out_ready low, the block SHALL hold at most 2 results, drop none, duplicate none, and keep out_sum stable while out_valid is high.
REQ-020 Approximate mode SHALL compute:
- c = x[P-1] & y[P-1].
- sum[P-1] = (c ? 0 : x[P-1] | y[P-1]) | (x[P-2] & y[P-2]).
- sum[P-2] = x[P-2] | y[P-2].
- sum[P-3:0] = all ones.
- sum[N:P] = x[N-1:P] + y[N-1:P] + c, exact, carry-out into bit N.
REQ-021 Exact mode SHALL compute out_sum = x + y in N+1 bits.
REQ-022 in_mode SHALL travel with its own operands, so mixed-mode back-to-back traffic produces per-transaction results.
REQ-023 Error monitor: on each output transfer of an approximate-mode result, let d = |approx - exact| (N+1 bits).
- If d != 0, err_cnt SHALL increment, saturating at all ones.
- err_max SHALL become max(err_max, d).
- Exact-mode results SHALL NOT affect the monitor.
REQ-024 err_clr SHALL zero err_cnt and err_max at the next edge; if a counted transfer occurs in the same cycle, the clear SHALL win.

Reset
REQ-025 While rst_n = 0 at a clock edge, the block SHALL set both stage valids to 0, out_sum to 0, err_cnt to 0 and err_max to 0.
REQ-026 In-flight transactions SHALL be discarded by reset and in_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 The outputs SHALL follow the reset state regardless of in_valid or out_ready during reset.

Configuration
REQ-028 Macro HOAANED_PIPE_ERR_MON_EN:
- Defined: the monitor of REQ-023 and REQ-024 SHALL be built, including the exact-sum comparison logic.
- Undefined: no monitor logic SHALL exist; err_cnt and err_max SHALL be constant 0 and err_clr SHALL be ignored.
- Ports SHALL be present in both builds.

Verification (N=16, P=8)
REQ-029 Approximate, x=0x00FF, y=0x0001 -> out_sum=0x000FF two cycles later; err_cnt=1, err_max=0x001 (monitor build).
REQ-030 Approximate, x=0x0080, y=0x0080 -> out_sum=0x0013F; err_max=0x03F.
REQ-031 Exact, x=0xFFFF, y=0x0001 -> out_sum=0x10000; err_cnt unchanged.
REQ-032 Stream 8 transactions with out_ready low for cycles 3-6 -> in_ready drops after 2 are held, all 8 results arrive in order, out_sum stable while stalled.
REQ-033 Assert rst_n=0 with 2 results in flight -> out_valid=0 next cycle, no stale result afterwards, monitor registers read 0.
REQ-034 err_clr coincident with a counted transfer -> err_cnt=0 and err_max=0 next cycle; without the macro, err_cnt=0 under all stimulus.
